// File: rtl/ibuffer_unpack.sv
// Instruction buffer: unpacks 128-bit fetch lines into {pc, inst} entries
// and presents the oldest entry first-word-fall-through to the decoder.
module ibuffer_unpack #(
    parameter int DEPTH    = 16,
    parameter int PC_WIDTH = 48
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    fetch_valid,
    output logic                    fetch_ready,
    input  logic [PC_WIDTH-1:0]     fetch_pc,
    input  logic [127:0]            fetch_inst,
    input  logic                    fifo_read_en,
    input  logic                    mem_stall,
    output logic                    ibuffer_instr_valid,
    output logic [31:0]             ibuffer_inst_out,
    output logic [PC_WIDTH-1:0]     ibuffer_pc_out,
    output logic                    fifo_empty,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_WIDTH-1:0] pc_mem_q   [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem_d   [DEPTH];
    logic [31:0]         inst_mem_q [DEPTH];
    logic [31:0]         inst_mem_d [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic                push;
    logic                pop;
    logic [1:0]          start;
    logic [2:0]          n;
    logic [PC_WIDTH-1:0] base;
    logic [2:0]          slot [4];

    assign start = fetch_pc[3:2];
    assign n     = 3'd4 - {1'b0, start};
    assign base  = {fetch_pc[PC_WIDTH-1:4], 4'b0000};

    assign fifo_empty  = (count_q == '0);
    assign fifo_count  = count_q;
    assign fetch_ready = (count_q <= CW'(DEPTH - 4)) & ~flush;

    assign push = fetch_valid & fetch_ready;
    assign pop  = fifo_read_en & ~mem_stall & ~fifo_empty;

    assign ibuffer_instr_valid = ~fifo_empty;
    assign ibuffer_inst_out    = fifo_empty ? 32'd0 : inst_mem_q[rptr_q];
    assign ibuffer_pc_out      = fifo_empty ? '0 : pc_mem_q[rptr_q];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot[i] = {1'b0, start} + 3'(i);
        end
    end

    // Only slots start..3 are valid; entry i lands at wptr+i modulo DEPTH.
    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < n) begin
                    pc_mem_d[wptr_q + AW'(i)] =
                        base + PC_WIDTH'({slot[i][1:0], 2'b00});
                    inst_mem_d[wptr_q + AW'(i)] =
                        fetch_inst[{slot[i][1:0], 5'b00000} +: 32];
                end
            end
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (reset || flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + AW'(n);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q
                    + (push ? CW'(n) : CW'(0))
                    - (pop ? CW'(1) : CW'(0));
        end
    end

    always_ff @(posedge clock) begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
    end

    // Storage needs no reset: reads are gated by the registered count.
    always_ff @(posedge clock) begin
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
    end

endmodule

// File: tb/tb_ibuffer_unpack.sv
// Self-checking bench for ibuffer_unpack: scoreboard queue of {pc, inst}
// entries filled on modelled pushes and drained on modelled pops.
module tb_ibuffer_unpack;

    localparam int DEPTH = 16;
    localparam int PW    = 48;

    logic            clock = 1'b0;
    logic            reset;
    logic            flush;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [PW-1:0]   fetch_pc;
    logic [127:0]    fetch_inst;
    logic            fifo_read_en;
    logic            mem_stall;
    logic            ibuffer_instr_valid;
    logic [31:0]     ibuffer_inst_out;
    logic [PW-1:0]   ibuffer_pc_out;
    logic            fifo_empty;
    logic [4:0]      fifo_count;

    int n_pass = 0;
    int n_total = 0;

    logic [PW+31:0] sb [$];

    always #5 clock = ~clock;

    ibuffer_unpack #(.DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
        .clock               (clock),
        .reset               (reset),
        .flush               (flush),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_pc            (fetch_pc),
        .fetch_inst          (fetch_inst),
        .fifo_read_en        (fifo_read_en),
        .mem_stall           (mem_stall),
        .ibuffer_instr_valid (ibuffer_instr_valid),
        .ibuffer_inst_out    (ibuffer_inst_out),
        .ibuffer_pc_out      (ibuffer_pc_out),
        .fifo_empty          (fifo_empty),
        .fifo_count          (fifo_count)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] mkline(input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    // One clock: drive, check head/ready, update model, check state after edge.
    task automatic cyc(input logic fv, input logic [PW-1:0] pc,
                       input logic [127:0] li, input logic rd,
                       input logic st, input logic fl, input logic rs);
        logic exp_ready;
        logic [PW-1:0] b;
        fetch_valid  = fv;
        fetch_pc     = pc;
        fetch_inst   = li;
        fifo_read_en = rd;
        mem_stall    = st;
        flush        = fl;
        reset        = rs;
        #1;
        exp_ready = (sb.size() <= DEPTH - 4) && !fl;
        check("fetch_ready", 64'(fetch_ready), 64'(exp_ready));
        check("instr_valid", 64'(ibuffer_instr_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("head_pc", 64'(ibuffer_pc_out), 64'(sb[0][PW+31:32]));
            check("head_inst", 64'(ibuffer_inst_out), 64'(sb[0][31:0]));
        end else begin
            check("empty_pc", 64'(ibuffer_pc_out), 64'd0);
            check("empty_inst", 64'(ibuffer_inst_out), 64'd0);
        end
        if (rs || fl) begin
            sb.delete();
        end else begin
            if (rd && !st && sb.size() != 0) void'(sb.pop_front());
            if (fv && exp_ready) begin
                b = {pc[PW-1:4], 4'b0000};
                for (int s = int'(pc[3:2]); s < 4; s++) begin
                    sb.push_back({b + PW'(4 * s), li[32*s +: 32]});
                end
            end
        end
        @(posedge clock);
        #1;
        check("fifo_count", 64'(fifo_count), 64'(sb.size()));
        check("fifo_empty", 64'(fifo_empty), 64'(sb.size() == 0));
    endtask

    task automatic push_line(input logic [PW-1:0] pc, input logic [127:0] li);
        cyc(1'b1, pc, li, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int k);
        for (int i = 0; i < k; i++) begin
            cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        fetch_valid  = 1'b0;
        fetch_pc     = '0;
        fetch_inst   = '0;
        fifo_read_en = 1'b0;
        mem_stall    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_empty", 64'(fifo_empty), 64'd1);
        check("rst_valid", 64'(ibuffer_instr_valid), 64'd0);
        check("rst_inst", 64'(ibuffer_inst_out), 64'd0);
        check("rst_pc", 64'(ibuffer_pc_out), 64'd0);
        check("rst_ready", 64'(fetch_ready), 64'd1);
        check("rst_count", 64'(fifo_count), 64'd0);
        reset = 1'b0;

        // Aligned line, then drain.
        push_line(48'h8000_0000, mkline(32'h11, 32'h22, 32'h33, 32'h44));
        check("line_count", 64'(fifo_count), 64'd4);
        check("line_head", 64'(ibuffer_inst_out), 64'h11);
        check("line_pc", 64'(ibuffer_pc_out), 64'h8000_0000);
        pop_n(4);

        // Misaligned start: only slots 2 and 3.
        push_line(48'h8000_0008, mkline(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        check("mis_count", 64'(fifo_count), 64'd2);
        check("mis_pc", 64'(ibuffer_pc_out), 64'h8000_0008);
        check("mis_inst", 64'(ibuffer_inst_out), 64'hA2);
        pop_n(2);

        // Fill to 13: ready drops; one pop brings it back.
        for (int i = 0; i < 3; i++) begin
            push_line(48'h9000_0000 + 48'(16 * i), {4{32'(i + 32'hB0)}} ^ 128'h3);
        end
        push_line(48'h9000_003C, mkline(1, 2, 3, 32'hBEEF));
        check("full13_count", 64'(fifo_count), 64'd13);
        check("full13_ready", 64'(fetch_ready), 64'd0);
        cyc(1'b1, 48'h9100_0000, '1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("after_pop_ready", 64'(fetch_ready), 64'd1);
        pop_n(12);

        // Simultaneous push and pop from count 5.
        push_line(48'hA000_0000, mkline(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        push_line(48'hA000_001C, mkline(0, 0, 0, 32'hC7));
        cyc(1'b1, 48'hA000_0020, mkline(32'hC8, 32'hC9, 32'hCA, 32'hCB),
            1'b1, 1'b0, 1'b0, 1'b0);
        check("pushpop_count", 64'(fifo_count), 64'd8);
        pop_n(8);

        // Wrap-around: put both pointers at 14, then push 4.
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_line(48'hB000_0000 + 48'(16 * i), {4{32'hD0 + 32'(i)}});
            pop_n(4);
        end
        push_line(48'hB000_0038, mkline(0, 0, 32'hD5, 32'hD6));
        pop_n(2);
        push_line(48'hB000_0040, mkline(32'hE0, 32'hE1, 32'hE2, 32'hE3));
        check("wrap_head", 64'(ibuffer_inst_out), 64'hE0);
        pop_n(4);

        // Flush with same-cycle push and pop at count 6.
        push_line(48'hC000_0000, mkline(1, 2, 3, 4));
        push_line(48'hC000_0018, mkline(5, 6, 7, 8));
        check("pre_flush_count", 64'(fifo_count), 64'd6);
        cyc(1'b1, 48'hC000_0020, mkline(9, 10, 11, 12), 1'b1, 1'b0, 1'b1, 1'b0);
        check("flush_count", 64'(fifo_count), 64'd0);
        check("flush_empty", 64'(fifo_empty), 64'd1);

        // Stall freezes pops.
        push_line(48'hD000_0000, mkline(32'hF0, 32'hF1, 32'hF2, 32'hF3));
        repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("stall_count", 64'(fifo_count), 64'd4);
        check("stall_head", 64'(ibuffer_inst_out), 64'hF0);

        // Reset mid-operation.
        cyc(1'b1, 48'hD100_0000, '1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("midrst_count", 64'(fifo_count), 64'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)),
                {16'h0, $urandom} & ~48'h3,
                {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 40) == 0),
                1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
